fp_result_capture: RTL

- Sequential writeback stage directly downstream of the combinational half-precision add/subtract unit.
- Registers each valid result word together with its status flags into a small first-word-fall-through FIFO, and presents them to the consumer with a valid/ready handshake.
- Maintains sticky exception flags (a CPSR-like accumulation) and a count of accepted operations.
- Decouples the adder's single-cycle combinational path from a consumer that may stall.

---
 rtl/fp_result_capture_pkg.sv | 53 +++++
 rtl/fp_result_capture_if.sv | 45 ++++
 rtl/fp_result_capture_sync_fifo_fwft.sv | 71 +++++++
 rtl/fp_result_capture.sv | 77 +++++++
 4 files changed

// File: rtl/fp_result_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_capture_pkg
// Description : Shared flag indices, special encodings and FIFO entry layout
//               for the half-precision result capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_result_capture_pkg;

    localparam int RESULT_W   = 16;
    localparam int FLAG_W     = 6;
    localparam int STICKY_W   = 4;
    localparam int ENTRY_W    = RESULT_W + FLAG_W;

    localparam int FLAG_NEG   = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_SUB   = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_INF   = 4;
    localparam int FLAG_NAN   = 5;

    localparam int STICKY_SUB = 0;
    localparam int STICKY_OVF = 1;
    localparam int STICKY_INF = 2;
    localparam int STICKY_NAN = 3;

    localparam logic [RESULT_W-1:0] NAN_ENC = 16'h7FFF;

    typedef struct packed {
        logic [FLAG_W-1:0]   flags;
        logic [RESULT_W-1:0] r;
    } entry_t;

    function automatic logic [RESULT_W-1:0] inf_enc(input logic s);
        return {s, 5'b11111, 10'b0};
    endfunction

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic nan, input logic inf, input logic ovf,
        input logic sub, input logic zero, input logic neg);
        logic [FLAG_W-1:0] f;
        f            = '0;
        f[FLAG_NAN]  = nan;
        f[FLAG_INF]  = inf;
        f[FLAG_OVF]  = ovf;
        f[FLAG_SUB]  = sub;
        f[FLAG_ZERO] = zero;
        f[FLAG_NEG]  = neg;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_result_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_capture_if
// Description : Producer/consumer handshake and status bundle of the capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_result_capture_if #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          in_r;
    logic                 in_negative;
    logic                 in_overflow;
    logic                 in_zero;
    logic                 in_inf;
    logic                 in_nan;
    logic                 in_subnormal;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_r;
    logic [5:0]           out_flags;
    logic [3:0]           sticky_flags;
    logic                 clear_sticky;
    logic [CNT_WIDTH-1:0] op_count;
    logic [LVL_W-1:0]     level;

    modport master (
        output in_valid, in_r, in_negative, in_overflow, in_zero, in_inf,
               in_nan, in_subnormal, out_ready, clear_sticky,
        input  in_ready, out_valid, out_r, out_flags, sticky_flags,
               op_count, level
    );

    modport slave (
        input  in_valid, in_r, in_negative, in_overflow, in_zero, in_inf,
               in_nan, in_subnormal, out_ready, clear_sticky,
        output in_ready, out_valid, out_r, out_flags, sticky_flags,
               op_count, level
    );
endinterface
`default_nettype wire

// File: rtl/fp_result_capture_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Synchronous first-word-fall-through FIFO, power-of-two depth.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       push_i,
    input  wire logic [WIDTH-1:0]           wdata_i,
    input  wire logic                       pop_i,
    output logic      [WIDTH-1:0]           rdata_o,
    output logic                            valid_o,
    output logic                            ready_o,
    output logic      [$clog2(DEPTH):0]     level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             w_full, w_empty, w_push, w_pop;

    assign w_full  = (level_q == LVL_W'(DEPTH));
    assign w_empty = (level_q == '0);
    // A full FIFO refuses the push even when the head pops in the same cycle.
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i & ~w_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = ~w_empty;
    assign ready_o = ~w_full;
    assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/fp_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_capture
// Description : Writeback stage queuing FP16 add/sub results with flags, plus
//               sticky exception accumulation and accepted-operation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_capture
    import fp_result_capture_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fp_result_capture_if.slave bus
);
    entry_t                 w_wdata;
    entry_t                 w_rdata;
    logic                   w_push, w_pop, w_in_ready, w_out_valid;
    logic [$clog2(DEPTH):0] w_level;
    logic [STICKY_W-1:0]    sticky_q, sticky_d, w_event;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    assign w_push = bus.in_valid & w_in_ready;
    assign w_pop  = w_out_valid & bus.out_ready;

    assign w_wdata.r     = bus.in_r;
    assign w_wdata.flags = pack_flags(bus.in_nan, bus.in_inf, bus.in_overflow,
                                      bus.in_subnormal, bus.in_zero, bus.in_negative);

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_rdata),
        .valid_o (w_out_valid),
        .ready_o (w_in_ready),
        .level_o (w_level)
    );

    always_comb begin
        w_event             = '0;
        w_event[STICKY_NAN] = bus.in_nan;
        w_event[STICKY_INF] = bus.in_inf;
        w_event[STICKY_OVF] = bus.in_overflow;
        w_event[STICKY_SUB] = bus.in_subnormal;
        // Clear is applied before OR-ing, so a same-cycle event survives it.
        sticky_d = (bus.clear_sticky ? '0 : sticky_q) | (w_push ? w_event : '0);
        count_d  = count_q + CNT_WIDTH'(w_push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_r        = w_rdata.r;
    assign bus.out_flags    = w_rdata.flags;
    assign bus.sticky_flags = sticky_q;
    assign bus.op_count     = count_q;
    assign bus.level        = w_level;

endmodule
`default_nettype wire
